systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 63 ++++++
 tb/tb_systolic_feeder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds A/B operand matrices and streams row/column slices into a systolic array.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_a_en,
  input  logic                 wr_b_en,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [N*W-1:0]       wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 acc_clr,
  output logic                 systolic_en,
  output logic [N*W-1:0]       a_vec,
  output logic [N*W-1:0]       b_vec,
  output logic                 done
);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic [N*W-1:0] a_buf [N];
  logic [N*W-1:0] b_buf [N];
  logic last, row_ok;
  assign last = k == KW'(N - 1);
  assign row_ok = 32'(wr_row) < N;
  always_comb
    state_nx = state == IDLE  ? (start ? CLEAR : IDLE) :
               state == CLEAR ? FEED :
               state == FEED  ? (last ? DONE : FEED) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k <= '0;
    end else begin
      state <= state_nx;
      k <= (state == FEED && !last) ? k + 1'b1 : '0;
    end
  // Operands only change in IDLE, so a running sequence always sees one consistent snapshot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        a_buf[r] <= '0;
        b_buf[r] <= '0;
      end
    end else if (state == IDLE && row_ok) begin
      if (wr_a_en) a_buf[wr_row] <= wr_data;
      if (wr_b_en) b_buf[wr_row] <= wr_data;
    end
  assign busy = state != IDLE;
  assign acc_clr = state == CLEAR;
  assign systolic_en = state == FEED;
  assign done = state == DONE;
  // Lane i of a_vec is column k of A row i; b_vec is row k of B as stored
  always_comb begin
    a_vec = '0;
    b_vec = systolic_en ? b_buf[k] : '0;
    for (int i = 0; i < N; i++)
      a_vec[i*W +: W] = systolic_en ? a_buf[i][32'(k)*W +: W] : '0;
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder (N=4 main instance, N=3 for out-of-range rows).
module tb_systolic_feeder;
  localparam int N = 4;
  typedef struct packed {logic clr; logic en; logic dn; logic [31:0] a; logic [31:0] b;} ent_t;
  logic clk = 0, rst = 0;
  logic wr_a_en = 0, wr_b_en = 0, start = 0;
  logic [1:0] wr_row = 0;
  logic [31:0] wr_data = 0;
  logic busy, acc_clr, systolic_en, done;
  logic [31:0] a_vec, b_vec;
  logic wr3_a = 0, wr3_b = 0, start3 = 0;
  logic [1:0] wr3_row = 0;
  logic [23:0] wr3_data = 0;
  logic busy3, clr3, en3, done3;
  logic [23:0] a3, b3;
  logic [31:0] ma [4];
  logic [31:0] mb [4];
  logic [23:0] m3a [3];
  logic [23:0] m3b [3];
  ent_t q[$];
  ent_t q3[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .wr_a_en(wr_a_en), .wr_b_en(wr_b_en), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .busy(busy), .acc_clr(acc_clr),
    .systolic_en(systolic_en), .a_vec(a_vec), .b_vec(b_vec), .done(done));

  systolic_feeder #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .wr_a_en(wr3_a), .wr_b_en(wr3_b), .wr_row(wr3_row),
    .wr_data(wr3_data), .start(start3), .busy(busy3), .acc_clr(clr3),
    .systolic_en(en3), .a_vec(a3), .b_vec(b3), .done(done3));

  task automatic chk(input string nm, input ent_t act, input ent_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push_seq(input int feeds, input bit with_done);
    q.push_back({3'b100, 64'h0});
    for (int k = 0; k < feeds; k++) begin
      ent_t e;
      e = '0;
      e.en = 1'b1;
      for (int i = 0; i < 4; i++) e.a[i*8 +: 8] = ma[i][k*8 +: 8];
      e.b = mb[k];
      q.push_back(e);
    end
    if (with_done) q.push_back({3'b001, 64'h0});
  endtask

  task automatic push_seq3();
    q3.push_back({3'b100, 64'h0});
    for (int k = 0; k < 3; k++) begin
      ent_t e;
      e = '0;
      e.en = 1'b1;
      for (int i = 0; i < 3; i++) e.a[i*8 +: 8] = m3a[i][k*8 +: 8];
      e.b = {8'h0, m3b[k]};
      q3.push_back(e);
    end
    q3.push_back({3'b001, 64'h0});
  endtask

  task automatic wr(input bit is_b, input logic [1:0] row, input logic [31:0] d);
    wr_row = row;
    wr_data = d;
    wr_a_en = !is_b;
    wr_b_en = is_b;
    @(posedge clk);
    #1 wr_a_en = 0;
    wr_b_en = 0;
  endtask

  task automatic wr3(input bit en_a, input bit en_b, input logic [1:0] row, input logic [23:0] d);
    wr3_row = row;
    wr3_data = d;
    wr3_a = en_a;
    wr3_b = en_b;
    @(posedge clk);
    #1 wr3_a = 0;
    wr3_b = 0;
  endtask

  task automatic run();
    start = 1;
    push_seq(N, 1);
    @(posedge clk);
    #1 start = 0;
    repeat (N + 2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!busy) chk("idle", {acc_clr, systolic_en, done, a_vec, b_vec}, '0);
    else if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL extra_output act=%h exp=none", {acc_clr, systolic_en, done, a_vec, b_vec});
    end else chk("seq", {acc_clr, systolic_en, done, a_vec, b_vec}, q.pop_front());
  end

  always @(negedge clk) begin
    if (!busy3) chk("idle3", {clr3, en3, done3, 8'h0, a3, 8'h0, b3}, '0);
    else if (q3.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL extra_output3 act=%h exp=none", {clr3, en3, done3, a3, b3});
    end else chk("seq3", {clr3, en3, done3, 8'h0, a3, 8'h0, b3}, q3.pop_front());
  end

  initial begin
    for (int r = 0; r < 4; r++) begin
      ma[r] = '0;
      mb[r] = '0;
    end
    #1 rst = 1;
    #1 chk("reset_out", {acc_clr, systolic_en, done, a_vec, b_vec}, '0);
    chk("reset_busy", {66'b0, busy}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // identity A, B rows {4r+1..4r+4}
    ma = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    mb = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    for (int r = 0; r < 4; r++) begin
      wr(0, 2'(r), ma[r]);
      wr(1, 2'(r), mb[r]);
    end
    run();
    // A all 2, B all -3
    for (int r = 0; r < 4; r++) begin
      ma[r] = 32'h02020202;
      mb[r] = 32'hFDFDFDFD;
      wr(0, 2'(r), ma[r]);
      wr(1, 2'(r), mb[r]);
    end
    run();
    // start and write during FEED k=1 are ignored
    start = 1;
    push_seq(N, 1);
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #1 start = 1;
    wr_a_en = 1;
    wr_row = 0;
    wr_data = 32'h7F7F7F7F;
    @(posedge clk);
    #1 start = 0;
    wr_a_en = 0;
    repeat (N) @(posedge clk);
    #1;
    // write row 2 on the start edge
    wr_row = 2;
    wr_data = 32'h08070605;
    wr_a_en = 1;
    ma[2] = 32'h08070605;
    start = 1;
    push_seq(N, 1);
    @(posedge clk);
    #1 start = 0;
    wr_a_en = 0;
    repeat (N + 2) @(posedge clk);
    #1;
    // abort at FEED k=2
    start = 1;
    push_seq(2, 0);
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 chk("abort_out", {acc_clr, systolic_en, done, a_vec, b_vec}, '0);
    chk("abort_busy", {66'b0, busy}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int r = 0; r < 4; r++) begin
      ma[r] = '0;
      mb[r] = '0;
    end
    run();
    // out-of-range row on the N=3 instance
    m3a = '{24'h030201, 24'h060504, 24'h090807};
    m3b = '{24'h7F80FF, 24'h0A0B0C, 24'h112233};
    for (int r = 0; r < 3; r++) begin
      wr3(1, 0, 2'(r), m3a[r]);
      wr3(0, 1, 2'(r), m3b[r]);
    end
    wr3(1, 1, 2'd3, 24'hEEEEEE);
    start3 = 1;
    push_seq3();
    @(posedge clk);
    #1 start3 = 0;
    repeat (6) @(posedge clk);
    #1 chk("queues_empty", ent_t'(67'(q.size() + q3.size())), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
